// File: rtl/time_ctrl_pkg.sv
// Shared types and defaults for the time-set front end (tick divider + key conditioners).
// Defaults assume a 50 MHz CLOCK_50.
package time_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPressDb,
        StHeld,
        StRepeat,
        StRelDb
    } key_state_e;

    localparam int unsigned DEFAULT_CLK_HZ       = 50_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYC = 1_000_000;
    localparam int unsigned DEFAULT_REPEAT_DELAY = 25_000_000;
    localparam int unsigned DEFAULT_REPEAT_RATE  = 5_000_000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Key inputs and pulse outputs between the time-set front end and the clock counter.
// master: the time_set_ctrl side; slave: the counter side.
interface time_set_ctrl_if;

    logic       key_sec_n;
    logic       key_min_n;
    logic       key_hr_n;
    logic       oneSec;
    logic       force_sec;
    logic       force_sec_n;
    logic       force_min;
    logic       force_min_n;
    logic       force_hr;
    logic       force_hr_n;
    logic [2:0] key_held;

    modport master (
        input  key_sec_n, key_min_n, key_hr_n,
        output oneSec, force_sec, force_sec_n, force_min, force_min_n, force_hr, force_hr_n,
        output key_held
    );

    modport slave (
        output key_sec_n, key_min_n, key_hr_n,
        input  oneSec, force_sec, force_sec_n, force_min, force_min_n, force_hr, force_hr_n,
        input  key_held
    );

endinterface

// File: rtl/key_conditioner.sv
// Synchronizes and debounces one active-low key into press/release pulses.
// TIME_SET_AUTO_REPEAT_EN builds the auto-repeat path (REPEAT state and rep counter).
module key_conditioner
    import time_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic release_set,
    output logic held
);

    localparam int unsigned CntW = cnt_width(max3(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_RATE));
    localparam logic [CntW-1:0] DbcLast = CntW'(DEBOUNCE_CYC - 1);
`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);
`endif

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == {CntW{1'b1}}) ? v : v + CntW'(1);
    endfunction

    logic [1:0]      sync_q;
    logic            synced;
    key_state_e      state_q, state_d;
    logic [CntW-1:0] dbc_q, dbc_d;
`ifdef TIME_SET_AUTO_REPEAT_EN
    logic [CntW-1:0] rep_q, rep_d;
`endif
    // *_fire_q mark the decision; the pulse registers below follow one cycle later.
    logic            press_fire_q, press_fire_d;
    logic            rel_fire_q, rel_fire_d;
    logic            press_q, release_q, held_q, held_d;

    assign synced = sync_q[1];

    always_comb begin
        state_d      = state_q;
        dbc_d        = dbc_q;
`ifdef TIME_SET_AUTO_REPEAT_EN
        rep_d        = rep_q;
`endif
        press_fire_d = 1'b0;
        rel_fire_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!synced) begin
                    state_d = StPressDb;
                    dbc_d   = '0;
                end
            end
            StPressDb: begin
                if (synced) begin
                    state_d = StIdle;
                end else if (dbc_q == DbcLast) begin
                    state_d      = StHeld;
                    press_fire_d = 1'b1;
`ifdef TIME_SET_AUTO_REPEAT_EN
                    rep_d        = '0;
`endif
                end else begin
                    dbc_d = sat_inc(dbc_q);
                end
            end
            StHeld: begin
                if (synced) begin
                    state_d = StRelDb;
                    dbc_d   = '0;
                end
`ifdef TIME_SET_AUTO_REPEAT_EN
                else if (rep_q == DelayLast) begin
                    state_d      = StRepeat;
                    rep_d        = '0;
                    press_fire_d = 1'b1;
                end else begin
                    rep_d = sat_inc(rep_q);
                end
`endif
            end
`ifdef TIME_SET_AUTO_REPEAT_EN
            StRepeat: begin
                if (synced) begin
                    state_d = StRelDb;
                    dbc_d   = '0;
                end else if (rep_q == RateLast) begin
                    rep_d        = '0;
                    press_fire_d = 1'b1;
                end else begin
                    rep_d = sat_inc(rep_q);
                end
            end
`endif
            StRelDb: begin
                if (!synced) begin
                    state_d = StHeld;
`ifdef TIME_SET_AUTO_REPEAT_EN
                    rep_d   = '0;
`endif
                end else if (dbc_q == DbcLast) begin
                    state_d    = StIdle;
                    rel_fire_d = 1'b1;
                end else begin
                    dbc_d = sat_inc(dbc_q);
                end
            end
            default: state_d = StIdle;
        endcase
        held_d = state_d inside {StHeld, StRepeat, StRelDb};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= 2'b11;
            state_q      <= StIdle;
            dbc_q        <= '0;
`ifdef TIME_SET_AUTO_REPEAT_EN
            rep_q        <= '0;
`endif
            press_fire_q <= 1'b0;
            rel_fire_q   <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            held_q       <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], key_n};
            state_q      <= state_d;
            dbc_q        <= dbc_d;
`ifdef TIME_SET_AUTO_REPEAT_EN
            rep_q        <= rep_d;
`endif
            press_fire_q <= press_fire_d;
            rel_fire_q   <= rel_fire_d;
            press_q      <= press_fire_q;
            release_q    <= rel_fire_q;
            held_q       <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign release_set   = rel_fire_q;
    assign held          = held_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set front end: 1 Hz strobe divider plus three key conditioners (sec/min/hr).
// TIME_SET_AUTO_REPEAT_EN enables auto-repeat of force pulses while a key is held.
module time_set_ctrl
    import time_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV     = DEFAULT_CLK_HZ,
    parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
    parameter int unsigned REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    time_set_ctrl_if.master bus
);

    localparam int unsigned TickW = cnt_width(TICK_DIV);
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

    logic [2:0]       keys_n;
    logic [2:0]       press, rel, rel_set, held;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             one_sec_q, one_sec_d;

    assign keys_n = {bus.key_hr_n, bus.key_min_n, bus.key_sec_n};

    for (genvar k = 0; k < 3; k++) begin : g_key
        key_conditioner #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_key (
            .clk           (CLOCK_50),
            .rst           (reset),
            .key_n         (keys_n[k]),
            .press_pulse   (press[k]),
            .release_pulse (rel[k]),
            .release_set   (rel_set[k]),
            .held          (held[k])
        );
    end

    // A release restarts the second so the counter gets a full second after resuming.
    always_comb begin
        tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TickW'(1);
        if (|rel_set) begin
            tick_cnt_d = '0;
        end
        one_sec_d = (tick_cnt_q == TickLast);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            one_sec_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            one_sec_q  <= one_sec_d;
        end
    end

    assign bus.oneSec      = one_sec_q;
    assign bus.force_sec   = press[0];
    assign bus.force_sec_n = rel[0];
    assign bus.force_min   = press[1];
    assign bus.force_min_n = rel[1];
    assign bus.force_hr    = press[2];
    assign bus.force_hr_n  = rel[2];
    assign bus.key_held    = held;

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Upstream stage for the clock counter.
- Divides CLOCK_50 into a one-cycle 1 Hz strobe (oneSec).
- Conditions three active-low push-buttons (seconds/minutes/hours set) into one-cycle force pulses on press, with optional auto-repeat while held, plus one-cycle release pulses (force_*_n). The counter uses the release pulses to resume running.
- Every output is registered and drives the counter's inputs of the same name directly.

Parameters:
- TICK_DIV, 50000000: CLOCK_50 cycles per oneSec strobe.
- DEBOUNCE_CYC, 1000000: cycles a key level must stay stable to be accepted (20 ms).
- REPEAT_DELAY, 25000000: cycles from an accepted press to the first auto-repeat pulse (0.5 s).
- REPEAT_RATE, 5000000: cycles between subsequent auto-repeat pulses (0.1 s).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- key_sec_n  in  1  raw seconds-set button, asynchronous, 0 = pressed.
- key_min_n  in  1  raw minutes-set button, 0 = pressed.
- key_hr_n  in  1  raw hours-set button, 0 = pressed.
- oneSec  out  1  one-cycle 1 Hz strobe.
- force_sec  out  1  one-cycle pulse: increment seconds.
- force_sec_n  out  1  one-cycle pulse: seconds key released.
- force_min  out  1  one-cycle pulse: increment minutes.
- force_min_n  out  1  one-cycle pulse: minutes key released.
- force_hr  out  1  one-cycle pulse: increment hours.
- force_hr_n  out  1  one-cycle pulse: hours key released.
- key_held  out  3  {hr,min,sec}: 1 while the key is in a debounced-pressed state.

Behaviour:
- Reset: all outputs 0; tick counter 0; synchronizer flops 1 (released); all key FSMs in IDLE.
- Reset mid-operation: no release pulse is emitted. A key still held after reset deasserts is treated as a fresh press: it is debounced, then pulses.
- Tick:
  - tick_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - oneSec = 1 in the cycle after tick_cnt == TICK_DIV-1 (registered).
  - Any force_*_n pulse forces tick_cnt to 0 in the same cycle, so the counter resumes with a full second before its next tick.
  - Counter width is clog2(TICK_DIV).
- Each key passes through a 2-flop synchronizer, then an independent FSM:
  - IDLE: synced = 0 → PRESS_DB, dbc = 0.
  - PRESS_DB:
    - synced = 1 → IDLE, no pulse.
    - Otherwise dbc increments.
    - At dbc == DEBOUNCE_CYC-1 → HELD, rep = 0, force pulse asserted next cycle.
  - HELD:
    - synced = 1 → REL_DB, dbc = 0.
    - Otherwise rep increments; at rep == REPEAT_DELAY-1 → REPEAT, rep = 0, force pulse.
  - REPEAT:
    - synced = 1 → REL_DB.
    - Otherwise, at rep == REPEAT_RATE-1: force pulse, rep = 0.
  - REL_DB:
    - synced = 0 → HELD, rep = 0, no pulse.
    - Stable 1 for DEBOUNCE_CYC cycles → IDLE, force_*_n pulse next cycle.
  - key_held = 1 in HELD, REPEAT and REL_DB.
- Latency: first force pulse is high exactly 2 + DEBOUNCE_CYC + 1 cycles after the first CLOCK_50 edge that samples key = 0. Release pulse has the same latency from the first edge sampling key = 1.
- Force pulses are never longer than 1 cycle. Consecutive pulses on the same output are separated by at least REPEAT_RATE-1 low cycles.
- Keys are fully independent. Simultaneous pulses on different outputs, and coincidence with oneSec, are legal and passed through unmodified.
- Debounce and repeat counters are sized clog2 of the largest of DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_RATE. They saturate and never wrap.

Optional Feature:
- Macro: TIME_SET_AUTO_REPEAT_EN.
- Defined: HELD/REPEAT behaviour as above.
- Undefined: the REPEAT state and rep counter are not built. HELD waits only for release, so exactly one force pulse is produced per press regardless of hold time. REPEAT_DELAY and REPEAT_RATE are unused.

Decomposition:
- Package time_ctrl_pkg holds:
  - key FSM state enum: IDLE, PRESS_DB, HELD, REPEAT, REL_DB.
  - default constants for CLK_HZ, DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_RATE.
- Sub-module key_conditioner contains synchronizer, FSM and counters, and outputs press_pulse, release_pulse, held. It is instantiated three times.
- The tick divider stays in the top level.

Test Plan (TICK_DIV=8, DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3):
- Reset released, keys idle → oneSec high 1 cycle every 8 cycles; all force outputs stay 0.
- key_sec_n low for 3 cycles then high (bounce) → no force_sec, no force_sec_n, key_held stays 0.
- key_min_n held low 12 cycles then released → force_min pulses once, 7 cycles after the first edge sampling 0; force_min_n pulses once 7 cycles after release; tick_cnt restarts so oneSec follows 8 cycles later.
- With TIME_SET_AUTO_REPEAT_EN, key_hr_n held low 40 cycles → force_hr pulses at the accept cycle, +10, then every 3 cycles; without the macro → exactly 1 pulse.
- key_sec_n and key_hr_n pressed on the same edge → force_sec and force_hr asserted in the same cycle.
- reset asserted while key_min_n is held in REPEAT → outputs 0 immediately and no force_min_n. After reset deasserts with the key still low, force_min pulses again after 7 cycles.
